// File: rtl/color_manager_window_counter_if.sv
// Sync/porch inputs and pixel-window outputs between the sync generator,
// the window counter and the colour lookup stage.
interface color_manager_window_counter_if #(
    parameter int unsigned H_WIDTH = 11,
    parameter int unsigned V_WIDTH = 10
);
    logic               HSync;
    logic               VSync;
    logic [H_WIDTH-1:0] HBackPorch;
    logic [H_WIDTH-1:0] HFrontPorch;
    logic [V_WIDTH-1:0] VBackPorch;
    logic [V_WIDTH-1:0] VFrontPorch;
    logic               Pixel_Valid;
    logic [H_WIDTH-1:0] Pixel_X;
    logic [V_WIDTH-1:0] Pixel_Y;
    logic               Line_Start;
    logic               Frame_Start;
    logic               Frame_Done;

    modport master (
        output HSync, VSync, HBackPorch, HFrontPorch, VBackPorch, VFrontPorch,
        input  Pixel_Valid, Pixel_X, Pixel_Y, Line_Start, Frame_Start, Frame_Done
    );

    modport slave (
        input  HSync, VSync, HBackPorch, HFrontPorch, VBackPorch, VFrontPorch,
        output Pixel_Valid, Pixel_X, Pixel_Y, Line_Start, Frame_Start, Frame_Done
    );
endinterface

// File: rtl/color_manager_window_counter.sv
// 2-D active-window pixel counter: flags in-window pixels, emits zero-based X/Y and line/frame markers.
// Optional CM_WIN_SHADOW_EN: porch values are latched while VSync=0 and frozen for the frame.
module color_manager_window_counter #(
    parameter int unsigned H_WIDTH = 11,
    parameter int unsigned V_WIDTH = 10
) (
    input logic                          Clk,
    input logic                          Rst,
    color_manager_window_counter_if.slave bus
);
    logic [H_WIDTH-1:0] h_cnt;
    logic [V_WIDTH-1:0] l_cnt;
    logic               hsync_d;
    logic               vsync_d;
    logic               seen_pix;

    logic [H_WIDTH-1:0] h_back;
    logic [H_WIDTH-1:0] h_front;
    logic [V_WIDTH-1:0] v_back;
    logic [V_WIDTH-1:0] v_front;

    logic               pixel_valid_q;
    logic [H_WIDTH-1:0] pixel_x_q;
    logic [V_WIDTH-1:0] pixel_y_q;
    logic               line_start_q;
    logic               frame_start_q;
    logic               frame_done_q;

    logic h_in_c;
    logic v_in_c;
    logic in_win_c;
    logic line_start_c;
    logic frame_start_c;
    logic frame_done_c;

`ifdef CM_WIN_SHADOW_EN
    // Porch shadows track the inputs between frames and freeze during the frame
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            h_back  <= '0;
            h_front <= '0;
            v_back  <= '0;
            v_front <= '0;
        end else if (!bus.VSync) begin
            h_back  <= bus.HBackPorch;
            h_front <= bus.HFrontPorch;
            v_back  <= bus.VBackPorch;
            v_front <= bus.VFrontPorch;
        end
    end
`else
    always_comb begin
        h_back  = bus.HBackPorch;
        h_front = bus.HFrontPorch;
        v_back  = bus.VBackPorch;
        v_front = bus.VFrontPorch;
    end
`endif

    // Horizontal cycle counter and line counter, both saturating
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            h_cnt   <= '0;
            l_cnt   <= '0;
            hsync_d <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            hsync_d <= bus.HSync;
            vsync_d <= bus.VSync;
            if (!bus.HSync) begin
                h_cnt <= '0;
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + H_WIDTH'(1);
            end
            if (!bus.VSync) begin
                l_cnt <= '0;
            end else if (hsync_d && !bus.HSync && (l_cnt != '1)) begin
                l_cnt <= l_cnt + V_WIDTH'(1);
            end
        end
    end

    // Window decode on the registered counters
    always_comb begin
        h_in_c        = (h_cnt > h_back) && (h_cnt < h_front);
        v_in_c        = (l_cnt > v_back) && (l_cnt < v_front);
        in_win_c      = bus.HSync && bus.VSync && h_in_c && v_in_c;
        line_start_c  = in_win_c && !pixel_valid_q;
        frame_start_c = line_start_c && (l_cnt == V_WIDTH'(v_back + V_WIDTH'(1)));
        frame_done_c  = vsync_d && !bus.VSync && seen_pix;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pixel_valid_q <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            seen_pix      <= 1'b0;
        end else begin
            pixel_valid_q <= in_win_c;
            if (in_win_c && pixel_valid_q) begin
                pixel_x_q <= pixel_x_q + H_WIDTH'(1);
            end else begin
                pixel_x_q <= '0;
            end
            if (in_win_c) begin
                pixel_y_q <= V_WIDTH'(l_cnt - v_back - V_WIDTH'(1));
            end
            line_start_q  <= line_start_c;
            frame_start_q <= frame_start_c;
            frame_done_q  <= frame_done_c;
            // Sticky "frame had a pixel" flag, consumed by the Frame_Done pulse
            if (frame_done_c) begin
                seen_pix <= 1'b0;
            end else if (pixel_valid_q) begin
                seen_pix <= 1'b1;
            end
        end
    end

    assign bus.Pixel_Valid = pixel_valid_q;
    assign bus.Pixel_X     = pixel_x_q;
    assign bus.Pixel_Y     = pixel_y_q;
    assign bus.Line_Start  = line_start_q;
    assign bus.Frame_Start = frame_start_q;
    assign bus.Frame_Done  = frame_done_q;
endmodule

// File: tb/tb_color_manager_window_counter.sv
// Bench for color_manager_window_counter: directed window cases plus random frames
// against a per-cycle arithmetic model of the window rules.
module tb_color_manager_window_counter;
    localparam int unsigned HW = 8;
    localparam int unsigned VW = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    color_manager_window_counter_if #(.H_WIDTH(HW), .V_WIDTH(VW)) bus ();
    color_manager_window_counter #(.H_WIDTH(HW), .V_WIDTH(VW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_err = 0;
    int n_chk = 0;

    // Model state: cycles of HSync high so far, lines completed in frame, porches in effect
    int hc, lc, ey;
    int hb_e, hf_e, vb_e, vf_e;
    bit phs, pvs, pvalid, seen;
    // Observed tallies for the directed scenarios
    int obs_valid, obs_ls, obs_fs, obs_fd, line_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hc = 0; lc = 0; ey = 0;
        hb_e = 0; hf_e = 0; vb_e = 0; vf_e = 0;
        phs = 0; pvs = 0; pvalid = 0; seen = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, bus.Pixel_Valid, 0);
        check({tag, "_x"},     bus.Pixel_X, 0);
        check({tag, "_y"},     bus.Pixel_Y, 0);
        check({tag, "_ls"},    bus.Line_Start, 0);
        check({tag, "_fs"},    bus.Frame_Start, 0);
        check({tag, "_fd"},    bus.Frame_Done, 0);
    endtask

    task automatic set_porch(input int hb, input int hf, input int vb, input int vf);
        bus.HBackPorch  = HW'(hb);
        bus.HFrontPorch = HW'(hf);
        bus.VBackPorch  = VW'(vb);
        bus.VFrontPorch = VW'(vf);
    endtask

    // One clock: apply inputs, predict outputs from the rules, clock, compare
    task automatic tick(input bit hs, input bit vs);
        int hb, hf, vb, vf, ex;
        bit ev, els, efs, efd;
        bus.HSync = hs;
        bus.VSync = vs;
`ifdef CM_WIN_SHADOW_EN
        hb = hb_e; hf = hf_e; vb = vb_e; vf = vf_e;
`else
        hb = int'(bus.HBackPorch);  hf = int'(bus.HFrontPorch);
        vb = int'(bus.VBackPorch);  vf = int'(bus.VFrontPorch);
`endif
        ev  = hs && vs && (hc > hb) && (hc < hf) && (lc > vb) && (lc < vf);
        ex  = ev ? (hc - hb - 1) : 0;
        if (ev) ey = lc - vb - 1;
        els = ev && !pvalid;
        efs = els && (lc == vb + 1);
        efd = pvs && !vs && seen;

        hc = hs ? ((hc < 255) ? hc + 1 : 255) : 0;
        if (!vs)            lc = 0;
        else if (phs && !hs) lc = (lc < 255) ? lc + 1 : 255;
        if (!vs) begin
            hb_e = int'(bus.HBackPorch);  hf_e = int'(bus.HFrontPorch);
            vb_e = int'(bus.VBackPorch);  vf_e = int'(bus.VFrontPorch);
        end
        if (efd)         seen = 0;
        else if (pvalid) seen = 1;
        phs = hs; pvs = vs; pvalid = ev;

        @(posedge Clk);
        #1;
        check("valid", bus.Pixel_Valid, ev);
        check("x",     bus.Pixel_X, ex);
        check("y",     bus.Pixel_Y, ey);
        check("ls",    bus.Line_Start, els);
        check("fs",    bus.Frame_Start, efs);
        check("fd",    bus.Frame_Done, efd);
        obs_valid  += int'(bus.Pixel_Valid);
        line_valid += int'(bus.Pixel_Valid);
        obs_ls     += int'(bus.Line_Start);
        obs_fs     += int'(bus.Frame_Start);
        obs_fd     += int'(bus.Frame_Done);
    endtask

    task automatic line(input int hi, input int lo, input bit vs);
        line_valid = 0;
        repeat (hi) tick(1'b1, vs);
        repeat (lo) tick(1'b0, vs);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0);
    endtask

    task automatic clear_tally();
        obs_valid = 0; obs_ls = 0; obs_fs = 0; obs_fd = 0; line_valid = 0;
    endtask

    // Whole frame of equal lines, VSync dropped with HSync low
    task automatic frame(input int nlines, input int hi, input int lo);
        tick(1'b0, 1'b1);
        repeat (nlines) line(hi, lo, 1'b1);
        idle(3);
    endtask

    initial begin
        bus.HSync = 1'b0;
        bus.VSync = 1'b0;
        set_porch(0, 0, 0, 0);
        model_reset();
        clear_tally();

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check_zero("rst_init");
        Rst = 1'b1;

        // Reset asserted mid-frame while a pixel is valid
        set_porch(2, 7, 0, 3);
        idle(2);
        tick(1'b0, 1'b1);
        line(20, 5, 1'b1);
        repeat (5) tick(1'b1, 1'b1);
        check("pre_rst_valid", bus.Pixel_Valid, 1);
        #2;
        Rst = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) begin
            @(posedge Clk);
            #1;
            check_zero("rst_hold");
        end
        bus.HSync = 1'b0;
        bus.VSync = 1'b0;
        model_reset();
        Rst = 1'b1;
        idle(3);

        // Basic window: 4 pixels on line 2, none on line 1
        clear_tally();
        set_porch(2, 7, 0, 3);
        idle(2);
        tick(1'b0, 1'b1);
        line(20, 5, 1'b1);
        check("t2_line1_cnt", line_valid, 0);
        line(20, 5, 1'b1);
        check("t2_line2_cnt", line_valid, 4);
        idle(3);

        // Vertical window: lines 3 and 4 only, one frame start, one frame done
        clear_tally();
        set_porch(2, 7, 1, 4);
        idle(2);
        frame(6, 20, 5);
        check("t3_valid_cnt", obs_valid, 8);
        check("t3_ls_cnt", obs_ls, 2);
        check("t3_fs_cnt", obs_fs, 1);
        check("t3_fd_cnt", obs_fd, 1);

        // Empty horizontal window
        clear_tally();
        set_porch(5, 6, 0, 5);
        idle(2);
        frame(4, 20, 5);
        check("t4_valid_cnt", obs_valid, 0);
        check("t4_fd_cnt", obs_fd, 0);

        // Saturating horizontal counter
        clear_tally();
        set_porch(250, 255, 0, 3);
        idle(2);
        tick(1'b0, 1'b1);
        line(10, 3, 1'b1);
        line(300, 3, 1'b1);
        check("t5_line_cnt", line_valid, 4);
        idle(3);
        check("t5_valid_cnt", obs_valid, 4);

        // HSync dropped mid-window, then HSync/VSync falling together
        clear_tally();
        set_porch(2, 7, 0, 4);
        idle(2);
        tick(1'b0, 1'b1);
        line(10, 3, 1'b1);
        line(5, 3, 1'b1);
        check("t6_partial_cnt", line_valid, 2);
        repeat (12) tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("t6_same_fall_fd", bus.Frame_Done, 1);
        idle(2);

        // Porch change mid-frame
        clear_tally();
        set_porch(2, 7, 0, 10);
        idle(2);
        tick(1'b0, 1'b1);
        line(20, 5, 1'b1);
        line(20, 5, 1'b1);
        check("t7_before_cnt", line_valid, 4);
        set_porch(2, 5, 0, 10);
        line(20, 5, 1'b1);
`ifdef CM_WIN_SHADOW_EN
        check("t7_after_cnt", line_valid, 4);
`else
        check("t7_after_cnt", line_valid, 2);
`endif
        idle(3);
        tick(1'b0, 1'b1);
        line(20, 5, 1'b1);
        line(20, 5, 1'b1);
        check("t7_next_frame_cnt", line_valid, 2);
        idle(3);

        // Random frames against the model
        repeat (25) begin
            int hb, hf, vb, vf, nl;
            bit same_fall;
            hb = int'($urandom_range(0, 10));
            hf = hb + int'($urandom_range(0, 12));
            vb = int'($urandom_range(0, 3));
            vf = int'($urandom_range(0, 7));
            nl = int'($urandom_range(1, 7));
            same_fall = bit'($urandom_range(0, 1));
            set_porch(hb, hf, vb, vf);
            idle(int'($urandom_range(1, 3)));
            tick(1'b0, 1'b1);
            for (int i = 0; i < nl - 1; i++) begin
                line(int'($urandom_range(1, 25)), int'($urandom_range(1, 4)), 1'b1);
            end
            if (same_fall) begin
                repeat (hf + 2 + int'($urandom_range(0, 5))) tick(1'b1, 1'b1);
                idle(3);
            end else begin
                line(int'($urandom_range(1, 25)), int'($urandom_range(1, 4)), 1'b1);
                idle(3);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
